// File: rtl/tea_pkg.sv
// Shared TEA definitions: key-schedule constant, default round count,
// key word slicing and the FSM state type used by the encrypt/decrypt stages.
package tea_pkg;

    localparam logic [31:0] DELTA_DEF  = 32'h9E3779B9;
    localparam int          ROUNDS_DEF = 32;

    localparam int KW     = 32;
    localparam int K0_LSB = 96;
    localparam int K1_LSB = 64;
    localparam int K2_LSB = 32;
    localparam int K3_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_t;

    // Initial decrypt sum: the value encryption reaches after all rounds.
    function automatic logic [31:0] sum_init(logic [31:0] delta, int rounds);
        logic [63:0] prod;
        prod = 64'(delta) * 64'(rounds);
        return prod[31:0];
    endfunction

endpackage

// File: rtl/tea_round_dec.sv
// One combinational TEA decrypt round; v0 update uses the already
// updated v1, mirroring the reverse order of the encrypt round.
module tea_round_dec
    import tea_pkg::*;
(
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    input  logic [31:0] sum,
    input  logic [31:0] k0,
    input  logic [31:0] k1,
    input  logic [31:0] k2,
    input  logic [31:0] k3,
    output logic [31:0] v0_next,
    output logic [31:0] v1_next
);

    logic [31:0] f1;
    logic [31:0] f0;

    always_comb begin
        f1      = ((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3);
        v1_next = v1 - f1;
        f0      = ((v1_next << 4) + k0) ^ (v1_next + sum) ^ ((v1_next >> 5) + k1);
        v0_next = v0 - f0;
    end

endmodule

// File: rtl/tea_decrypt.sv
// Iterative TEA decryptor: one round per clock, valid/ready on both sides,
// three-state FSM with registered handshake outputs.
module tea_decrypt
    import tea_pkg::*;
#(
    parameter int          ROUNDS = ROUNDS_DEF,
    parameter logic [31:0] DELTA  = DELTA_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_v0,
    input  logic [31:0]  in_v1,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_v0,
    output logic [31:0]  out_v1,
    output logic         busy
);

    localparam logic [31:0] SUM_INIT = sum_init(DELTA, ROUNDS);
    localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);

    tea_state_t   state;
    tea_state_t   state_n;
    logic [31:0]  v0;
    logic [31:0]  v1;
    logic [31:0]  sum;
    logic [127:0] k;
    logic [5:0]   cnt;
    logic [31:0]  v0_nx;
    logic [31:0]  v1_nx;
    logic         last;

    tea_round_dec u_round (
        .v0      (v0),
        .v1      (v1),
        .sum     (sum),
        .k0      (k[K0_LSB +: KW]),
        .k1      (k[K1_LSB +: KW]),
        .k2      (k[K2_LSB +: KW]),
        .k3      (k[K3_LSB +: KW]),
        .v0_next (v0_nx),
        .v1_next (v1_nx)
    );

    assign last = (cnt == LAST_RND);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid)  state_n = RUN;
            RUN:     if (last)      state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_v0    <= '0;
            out_v1    <= '0;
            v0        <= '0;
            v1        <= '0;
            sum       <= '0;
            k         <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            busy      <= (state_n != IDLE);
            // Data registers only move on the accepting edge or a round edge.
            if (state == IDLE && in_valid) begin
                v0  <= in_v0;
                v1  <= in_v1;
                k   <= key;
                sum <= SUM_INIT;
                cnt <= '0;
            end else if (state == RUN) begin
                v0  <= v0_nx;
                v1  <= v1_nx;
                sum <= sum - DELTA;
                cnt <= cnt + 6'd1;
                if (last) begin
                    out_v0 <= v0_nx;
                    out_v1 <= v1_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_tea_decrypt.sv
// Self-checking bench for tea_decrypt: vector table, random jobs against a
// plain-arithmetic TEA model, and hand-written handshake/reset sequences.
module tb_tea_decrypt;

    localparam int          NR = 32;
    localparam logic [31:0] DL = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_v0;
    logic [31:0]  in_v1;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_v0;
    logic [31:0]  out_v1;
    logic         busy;

    int tests = 0;
    int fails = 0;

    tea_decrypt #(.ROUNDS(NR), .DELTA(DL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_v0     (in_v0),
        .in_v1     (in_v1),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v0    (out_v0),
        .out_v1    (out_v1),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  v0;
        logic [31:0]  v1;
        logic [127:0] k;
        logic [31:0]  e0;
        logic [31:0]  e1;
    } vec_t;

    function automatic logic [63:0] ref_enc(logic [31:0] a, logic [31:0] b,
                                            logic [127:0] kk);
        logic [31:0] s = 0;
        for (int i = 0; i < NR; i++) begin
            s = s + DL;
            a = a + (((b << 4) + kk[127:96]) ^ (b + s) ^ ((b >> 5) + kk[95:64]));
            b = b + (((a << 4) + kk[63:32]) ^ (a + s) ^ ((a >> 5) + kk[31:0]));
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] ref_dec(logic [31:0] a, logic [31:0] b,
                                            logic [127:0] kk);
        logic [31:0] s = DL * NR;
        for (int i = 0; i < NR; i++) begin
            b = b - (((a << 4) + kk[63:32]) ^ (a + s) ^ ((a >> 5) + kk[31:0]));
            a = a - (((b << 4) + kk[127:96]) ^ (b + s) ^ ((b >> 5) + kk[95:64]));
            s = s - DL;
        end
        return {a, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input logic [127:0] kk, input int hold,
                           output logic [31:0] r0, output logic [31:0] r1,
                           output int lat);
        bit ok = 0;
        r0 = '0;
        r1 = '0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin chk("wait_in_ready", 0, 1); return; end
        in_valid = 1'b1;
        in_v0 = a;
        in_v1 = b;
        key = kk;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) begin chk("wait_out_valid", 0, 1); return; end
        r0 = out_v0;
        r1 = out_v1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_data", {out_v0, out_v1}, {r0, r1});
            chk("hold_flags", {out_valid, in_ready, busy}, 3'b101);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("back_to_idle", {in_ready, out_valid, busy}, 3'b100);
    endtask

    vec_t         tbl[6];
    logic [31:0]  r0, r1, a0, a1;
    logic [63:0]  p, c, m;
    logic [127:0] kk;
    int           lat, acc_edge, k_edge;
    bit           rdy, got;

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_v0 = '0;
        in_v1 = '0;
        key = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_flags", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_data", {out_v0, out_v1}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{32'h5CF85E83, 32'hE967E1FD,
                   128'h11111111_22222222_33333333_44444444,
                   32'h12345678, 32'h9ABCDEF0};
        tbl[1] = '{32'h41EA3A0A, 32'h94BAA940, 128'd0, 32'd0, 32'd0};
        for (int i = 2; i < 6; i++) begin
            p  = {$urandom, $urandom};
            kk = {$urandom, $urandom, $urandom, $urandom};
            c  = ref_enc(p[63:32], p[31:0], kk);
            tbl[i] = '{c[63:32], c[31:0], kk, p[63:32], p[31:0]};
        end
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].v0, tbl[i].v1, tbl[i].k, 0, r0, r1, lat);
            chk($sformatf("vec%0d", i), {r0, r1}, {tbl[i].e0, tbl[i].e1});
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(NR));
        end

        for (int i = 0; i < 16; i++) begin
            a0 = $urandom;
            a1 = $urandom;
            kk = {$urandom, $urandom, $urandom, $urandom};
            m  = ref_dec(a0, a1, kk);
            run_job(a0, a1, kk, int'($urandom_range(0, 3)), r0, r1, lat);
            chk($sformatf("rand%0d", i), {r0, r1}, m);
        end

        run_job(tbl[0].v0, tbl[0].v1, tbl[0].k, 10, r0, r1, lat);
        chk("backpressure", {r0, r1}, {tbl[0].e0, tbl[0].e1});

        // Inputs scrambled every cycle while the job runs.
        in_valid = 1'b1;
        in_v0 = tbl[0].v0;
        in_v1 = tbl[0].v1;
        key = tbl[0].k;
        @(posedge clk);
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
            chk("iso_in_ready", in_ready, 1'b0);
            in_valid = 1'($urandom);
            in_v0 = $urandom;
            in_v1 = $urandom;
            key = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
        end
        in_valid = 1'b0;
        chk("iso_done", got, 1'b1);
        chk("iso_result", {out_v0, out_v1}, {tbl[0].e0, tbl[0].e1});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("iso_no_second", {in_ready, busy, out_valid}, 3'b100);

        // Abort at round 15.
        in_valid = 1'b1;
        in_v0 = tbl[0].v0;
        in_v1 = tbl[0].v1;
        key = tbl[0].k;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {busy, out_valid}, 2'b10);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        chk("abort_flags", {in_ready, out_valid, busy}, 3'b100);
        chk("abort_data", {out_v0, out_v1}, 64'd0);
        run_job(tbl[0].v0, tbl[0].v1, tbl[0].k, 0, r0, r1, lat);
        chk("after_abort", {r0, r1}, {tbl[0].e0, tbl[0].e1});

        // Back-to-back with out_ready held high; second job waits on in_valid.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_v0 = tbl[0].v0;
        in_v1 = tbl[0].v1;
        key = tbl[0].k;
        @(posedge clk);
        @(negedge clk);
        in_v0 = tbl[1].v0;
        in_v1 = tbl[1].v1;
        key = tbl[1].k;
        k_edge = 0;
        acc_edge = -1;
        a0 = '1;
        a1 = '1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            rdy = in_ready;
            @(posedge clk);
            k_edge++;
            @(negedge clk);
            if (rdy && in_valid && acc_edge < 0) begin
                acc_edge = k_edge;
                in_valid = 1'b0;
            end
            if (out_valid && acc_edge < 0) begin
                a0 = out_v0;
                a1 = out_v1;
            end else if (out_valid) begin
                got = 1;
            end
        end
        chk("b2b_first", {a0, a1}, {tbl[0].e0, tbl[0].e1});
        chk("b2b_accept_edge", 64'(acc_edge), 64'(NR + 2));
        chk("b2b_second_done", got, 1'b1);
        chk("b2b_second", {out_v0, out_v1}, {tbl[1].e0, tbl[1].e1});
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle", {in_ready, busy}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tea_decrypt.md
TEA_DECRYPT -- requirements
Module: tea_decrypt

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 32: number of TEA rounds; legal range 1..63.
REQ-002 The block SHALL have parameter DELTA, default 32'h9E3779B9: TEA key-schedule constant.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: ciphertext and key present on the input bus.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a new job.
REQ-007 The block SHALL have port in_v0, input, 32 bits: ciphertext word 0.
REQ-008 The block SHALL have port in_v1, input, 32 bits: ciphertext word 1.
REQ-009 The block SHALL have port key, input, 128 bits: k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0].
REQ-010 The block SHALL have port out_valid, output, 1 bit: plaintext result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port out_v0, output, 32 bits: plaintext word 0.
REQ-013 The block SHALL have port out_v1, output, 32 bits: plaintext word 1.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both outputs SHALL be registered.
REQ-017 When in_valid=1 and in_ready=1 at an edge, the block SHALL capture in_v0, in_v1 and all of key into internal registers, load sum = DELTA*ROUNDS mod 2^32 (32'hC6EF3720 for the defaults), clear the round counter and enter RUN.
REQ-018 Each RUN cycle SHALL perform one round, all arithmetic modulo 2^32, with shifts logical:
- v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
- then v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using the updated v1
- then sum -= DELTA
REQ-019 After the ROUNDS-th round the block SHALL enter DONE, with out_v0/out_v1 equal to the final v0/v1; out_valid SHALL rise exactly ROUNDS edges after the accepting edge.
REQ-020 In DONE, out_v0/out_v1 SHALL hold stable while out_ready=0, for any number of cycles.
REQ-021 In DONE with out_ready=1, the block SHALL return to IDLE on that edge, so in_ready=1 on the next cycle; minimum job spacing is ROUNDS+2 cycles.
REQ-022 Input changes on in_v0, in_v1 or key SHALL have no effect outside the accepting edge; in_valid outside IDLE SHALL be ignored.
REQ-023 The round counter SHALL be 6 bits wide and SHALL never wrap during a job.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 When reset_n=0 at an edge, the block SHALL set state=IDLE, in_ready=1, out_valid=0, busy=0, out_v0=0, out_v1=0, round counter=0, sum=0 and the data and key registers to 0.
REQ-026 reset_n=0 SHALL take priority over every handshake, including mid-RUN and DONE; an aborted job SHALL produce no output.
REQ-027 No state SHALL change asynchronously to clk.

Structure
REQ-028 A shared package tea_pkg SHALL hold DELTA, the default ROUNDS, the key word slicing constants and the FSM state type; it is shared with the encrypt stage.
REQ-029 One combinational sub-module, tea_round_dec, SHALL compute one decrypt round: inputs v0, v1, sum and k0..k3; outputs the next v0 and v1.
REQ-030 The whole block SHALL be 120-400 lines of RTL, with no multicycle paths.

Verification
REQ-031 Known vector: ciphertext 5CF85E83/E967E1FD with key 11111111_22222222_33333333_44444444 -> out_v0=12345678, out_v1=9ABCDEF0, out_valid rising 32 edges after acceptance.
REQ-032 Zero-key vector: ciphertext 41EA3A0A/94BAA940 with key 0 -> out_v0=00000000, out_v1=00000000.
REQ-033 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-034 Input isolation: change key and ciphertext on every cycle during RUN, and pulse in_valid -> result equals the REQ-031 value and no second job is accepted.
REQ-035 Reset mid-RUN: drop reset_n at round 15 -> next cycle IDLE, out_valid=0, outputs 0; a new job after reset returns the correct result.
REQ-036 Back-to-back: two jobs with out_ready held at 1 -> second acceptance 34 edges after the first, both results correct.
